debam_seq_divider: RTL and testbench

DEBAM_SEQ_DIVIDER -- requirements
Module: debam_seq_divider

---
 rtl/debam_div_pkg.sv | 22 ++
 rtl/debam_div_digit_sel.sv | 46 ++++
 rtl/debam_seq_divider.sv | 131 +++++++++++++
 tb/tb_debam_seq_divider.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/debam_div_pkg.sv
// Shared definitions for the radix-4 sequential divider.
//   state_e    : divider FSM states
//   Digit0..3  : radix-4 quotient digit encodings
//   cnt_width(): width of the digit-iteration counter for a given iteration count
package debam_div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [1:0] Digit0 = 2'd0;
  localparam logic [1:0] Digit1 = 2'd1;
  localparam logic [1:0] Digit2 = 2'd2;
  localparam logic [1:0] Digit3 = 2'd3;

  function automatic int unsigned cnt_width(input int unsigned iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

endpackage

// File: rtl/debam_div_digit_sel.sv
// Radix-4 quotient digit selection (purely combinational).
// Compares the extended partial remainder against B, 2B and 3B, turns the
// resulting thermometer code into a one-hot select and returns the digit and
// the selected multiple.
//   r_ext_i : extended partial remainder {R, next two dividend bits}, N+2 bits
//   b_i     : divisor, N bits (non-zero while in use)
//   digit_o : quotient digit, 0..3
//   mult_o  : low N bits of digit*B
module debam_div_digit_sel
  import debam_div_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N+1:0] r_ext_i,
  input  logic [N-1:0] b_i,
  output logic [1:0]   digit_o,
  output logic [N-1:0] mult_o
);

  logic [N+1:0] b1, b2, b3;
  logic [2:0]   therm;
  logic [3:0]   onehot;

  assign b1 = {2'b00, b_i};
  assign b2 = {1'b0, b_i, 1'b0};
  assign b3 = b1 + b2;

  // Multiples are monotone, so the compare results form a thermometer code.
  assign therm  = {(r_ext_i >= b3), (r_ext_i >= b2), (r_ext_i >= b1)};
  assign onehot = {therm[2], therm[1] & ~therm[2], therm[0] & ~therm[1], ~therm[0]};

  // Only the low N bits of the multiple are needed: R' - digit*B < B fits in
  // N bits, so the subtraction can be done modulo 2^N.
  always_comb begin
    digit_o = Digit0;
    mult_o  = '0;
    unique case (1'b1)
      onehot[0]: begin digit_o = Digit0; mult_o = '0;          end
      onehot[1]: begin digit_o = Digit1; mult_o = b1[N-1:0];   end
      onehot[2]: begin digit_o = Digit2; mult_o = b2[N-1:0];   end
      onehot[3]: begin digit_o = Digit3; mult_o = b3[N-1:0];   end
      default:   begin digit_o = Digit0; mult_o = '0;          end
    endcase
  end

endmodule

// File: rtl/debam_seq_divider.sv
// Sequential unsigned radix-4 divider with valid/ready handshakes.
// One quotient digit (2 bits) per RUN cycle, MSB digit first.
// Optional macro DEBAM_DIV_APPROX_EN: skip the K lowest digit iterations; the
// low 2K quotient bits read as zero and the unconsumed dividend bits are folded
// into REMAINDER so that A == QUOTIENT*B + REMAINDER still holds.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   IN_VALID/IN_READY   : operand handshake (ready only in IDLE)
//   A, B                : dividend, divisor
//   OUT_VALID/OUT_READY : result handshake (valid only in DONE)
//   QUOTIENT, REMAINDER : result; all ones / A on divide-by-zero
//   DIV0                : divisor was zero
module debam_seq_divider
  import debam_div_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned K = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] QUOTIENT,
  output logic [N-1:0] REMAINDER,
  output logic         DIV0
);

`ifdef DEBAM_DIV_APPROX_EN
  localparam bit ApproxEn = 1'b1;
`else
  localparam bit ApproxEn = 1'b0;
`endif

  localparam int unsigned Skip  = ApproxEn ? K : 0;
  localparam int unsigned Iters = N / 2 - Skip;
  localparam int unsigned CntW  = cnt_width(Iters);
  localparam logic [CntW-1:0] CntStart = CntW'(Iters - 1);

  state_e          state_q;
  logic [N-1:0]    a_q, b_q, r_q, q_q;
  logic [CntW-1:0] cnt_q;
  logic            div0_q;

  logic [N+1:0]    r_ext;
  logic [1:0]      digit;
  logic [N-1:0]    mult;
  logic [N-1:0]    r_d, q_d, a_d, rem_fin;

  assign r_ext = {r_q, a_q[N-1 -: 2]};

  debam_div_digit_sel #(
    .N (N)
  ) u_digit_sel (
    .r_ext_i (r_ext),
    .b_i     (b_q),
    .digit_o (digit),
    .mult_o  (mult)
  );

  always_comb begin
    r_d = r_ext[N-1:0] - mult;
    q_d = {q_q[N-3:0], digit};
    a_d = a_q << 2;
`ifdef DEBAM_DIV_APPROX_EN
    // {final partial remainder, unconsumed low dividend bits}, truncated to N.
    rem_fin = N'({r_d, a_d} >> (N - 2 * Skip));
`else
    rem_fin = r_d;
`endif
  end

  // r_q and q_q double as the REMAINDER/QUOTIENT output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (IN_VALID) begin
            if (B == '0) begin
              q_q     <= '1;
              r_q     <= A;
              div0_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              a_q     <= A;
              b_q     <= B;
              r_q     <= '0;
              q_q     <= '0;
              cnt_q   <= CntStart;
              div0_q  <= 1'b0;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          a_q <= a_d;
          if (cnt_q == '0) begin
            q_q     <= q_d << (2 * Skip);
            r_q     <= rem_fin;
            state_q <= StDone;
          end else begin
            q_q   <= q_d;
            r_q   <= r_d;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (OUT_READY) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign IN_READY  = (state_q == StIdle);
  assign OUT_VALID = (state_q == StDone);
  assign QUOTIENT  = q_q;
  assign REMAINDER = r_q;
  assign DIV0      = div0_q;

endmodule

// File: tb/tb_debam_seq_divider.sv
// Directed self-checking bench for debam_seq_divider (N=8, K=1).
module tb_debam_seq_divider;

  localparam int unsigned N = 8;
  localparam int unsigned K = 1;

`ifdef DEBAM_DIV_APPROX_EN
  localparam int LatRun  = 4;
  localparam logic [7:0] Q255 = 8'd252, R255 = 8'd3;
  localparam logic [7:0] Q63  = 8'd4,   R63  = 8'd31;
`else
  localparam int LatRun  = 5;
  localparam logic [7:0] Q255 = 8'd255, R255 = 8'd0;
  localparam logic [7:0] Q63  = 8'd7,   R63  = 8'd7;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [N-1:0] a, b;
  logic         out_valid, out_ready;
  logic [N-1:0] quotient, remainder;
  logic         div0;

  int n_checks = 0;
  int n_pass   = 0;

  debam_seq_divider #(
    .N (N),
    .K (K)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .A         (a),
    .B         (b),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .QUOTIENT  (quotient),
    .REMAINDER (remainder),
    .DIV0      (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one cycle; returns just after the acceptance edge.
  task automatic start_div(input string tag, input logic [7:0] av, input logic [7:0] bv);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counted in cycles from the acceptance cycle.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_res(input string tag, input logic [7:0] eq, input logic [7:0] er,
                           input logic ed);
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_div0"}, 32'(div0), 32'(ed));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  task automatic run_div(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] eq, input logic [7:0] er, input logic ed,
                         input int exp_lat);
    start_div(tag, av, bv);
    wait_done(tag, exp_lat);
    check_res(tag, eq, er, ed);
    release_out(tag);
  endtask

  initial begin
    bit seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check("rst_outs", {21'd0, out_valid, div0, quotient, remainder}, 32'd0);
    #21;
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run_div("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, LatRun);
    run_div("d255_1", 8'd255, 8'd1, Q255, R255, 1'b0, LatRun);
    run_div("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, LatRun);
`ifdef DEBAM_DIV_APPROX_EN
    run_div("apx203_7", 8'd203, 8'd7, 8'd28, 8'd7, 1'b0, LatRun);
`endif
    run_div("d100_0", 8'd100, 8'd0, 8'd255, 8'd100, 1'b1, 1);

    // Stall in DONE while new operands are offered.
    start_div("stall", 8'd200, 8'd7);
    wait_done("stall", LatRun);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a        = 8'h11;
      b        = 8'h22;
      tick();
      check("stall_hold", {13'd0, out_valid, in_ready, div0, quotient, remainder},
            {13'd0, 1'b1, 1'b0, 1'b0, 8'd28, 8'd4});
    end
    // Operands (divide-by-zero) offered in the handover cycle must be dropped.
    in_valid = 1'b1;
    a        = 8'd9;
    b        = 8'd0;
    release_out("handover");
    in_valid = 1'b0;
    tick();
    check("handover_noacc", {30'd0, out_valid, in_ready}, 32'b01);

    // Reset during the second RUN cycle.
    start_div("abort", 8'd200, 8'd7);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_outs", {21'd0, out_valid, div0, quotient, remainder}, 32'd0);
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= out_valid;
    end
    check("abort_noresult", 32'(seen), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    run_div("d63_8", 8'd63, 8'd8, Q63, R63, 1'b0, LatRun);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
